mbus_timer: RTL and testbench

//  Memory-mapped down-counting timer, a responder on the CPU memory bus (mbus).

---
 rtl/mbus_timer_pkg.sv | 21 ++
 rtl/mbus_timer_if.sv | 14 +
 rtl/mbus_timer_presc.sv | 25 ++
 rtl/mbus_timer.sv | 106 ++++++++++
 tb/tb_mbus_timer.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/mbus_timer_pkg.sv
// Shared register offsets, control/status bit positions and run-state type
// for the mbus down-counting timer.
package mbus_timer_pkg;

  localparam int unsigned REG_CTRL   = 0;
  localparam int unsigned REG_RELOAD = 1;
  localparam int unsigned REG_COUNT  = 2;
  localparam int unsigned REG_STAT   = 3;
  localparam int unsigned REG_PRESC  = 4;

  localparam int unsigned CTRL_RUN = 0;
  localparam int unsigned CTRL_ARL = 1;
  localparam int unsigned CTRL_IE  = 2;
  localparam int unsigned STAT_UF  = 0;

  typedef enum logic {
    ST_STOP = 1'b0,
    ST_RUN  = 1'b1
  } run_state_t;

endpackage

// File: rtl/mbus_timer_if.sv
// Memory-bus responder port: chip select, register offset, write strobe and data.
interface mbus_timer_if #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned ADDR_SIZE = 4
) ();
   logic                 cs;
   logic [ADDR_SIZE-1:0] addr;
   logic                 wen;
   logic [WIDTH-1:0]     din;
   logic [WIDTH-1:0]     dout;

   modport master (output cs, addr, wen, din, input  dout);
   modport slave  (input  cs, addr, wen, din, output dout);
endinterface

// File: rtl/mbus_timer_presc.sv
// Reload down-counter: ticks when the count reaches zero while enabled,
// and holds the reload value whenever disabled or explicitly loaded.
module tmr_presc #(
   parameter int unsigned PRE_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 en,
   input  logic                 load,
   input  logic [PRE_WIDTH-1:0] val,
   output logic                 tick
);
   logic [PRE_WIDTH-1:0] pc;

   assign tick = en && (pc == '0);

   always_ff @(posedge clk) begin
      if (reset)
         pc <= '0;
      else if (load || !en || tick)
         pc <= val;
      else
         pc <= pc - PRE_WIDTH'(1);
   end
endmodule

// File: rtl/mbus_timer.sv
// Memory-mapped down-counting timer on the CPU mbus: CTRL/RELOAD/COUNT/STAT/PRESC
// registers, prescaled tick, one-shot or auto-reload underflow and a level irq.
module mbus_timer
   import mbus_timer_pkg::*;
#(
   parameter int unsigned WIDTH     = 32,
   parameter int unsigned ADDR_SIZE = 4,
   parameter int unsigned PRE_WIDTH = 16
) (
   input  logic         clk,
   input  logic         reset,
   mbus_timer_if.slave  bus,
   output logic         irq
);
   run_state_t           state;
   logic                 arl, ie, uf;
   logic [WIDTH-1:0]     reload, count;
   logic [PRE_WIDTH-1:0] presc;
   logic                 tick, uf_ev, run;
   logic                 wr, wr_ctrl, wr_reload, wr_count, wr_stat, wr_presc;
   logic                 pre_load;
   logic [PRE_WIDTH-1:0] pre_val;
   logic [WIDTH-1:0]     rdata;

   assign run       = (state == ST_RUN);
   assign wr        = bus.cs && bus.wen;
   assign wr_ctrl   = wr && (bus.addr == ADDR_SIZE'(REG_CTRL));
   assign wr_reload = wr && (bus.addr == ADDR_SIZE'(REG_RELOAD));
   assign wr_count  = wr && (bus.addr == ADDR_SIZE'(REG_COUNT));
   assign wr_stat   = wr && (bus.addr == ADDR_SIZE'(REG_STAT));
   assign wr_presc  = wr && (bus.addr == ADDR_SIZE'(REG_PRESC));

   // A PRESC write restarts the prescaler from the value being written, not the old one.
   assign pre_load = wr_presc || (wr_ctrl && bus.din[CTRL_RUN] && !run);
   assign pre_val  = wr_presc ? bus.din[PRE_WIDTH-1:0] : presc;

   tmr_presc #(.PRE_WIDTH(PRE_WIDTH)) u_presc (
      .clk   (clk),
      .reset (reset),
      .en    (run),
      .load  (pre_load),
      .val   (pre_val),
      .tick  (tick)
   );

   assign uf_ev = tick && (count == '0);

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= ST_STOP;
         arl    <= 1'b0;
         ie     <= 1'b0;
         uf     <= 1'b0;
         reload <= '0;
         count  <= '0;
         presc  <= '0;
      end else begin
         if (wr_reload) reload <= bus.din;
         if (wr_presc)  presc  <= bus.din[PRE_WIDTH-1:0];

         if (wr_count)
            count <= bus.din;
         else if (tick && count != '0)
            count <= count - WIDTH'(1);
         else if (uf_ev && arl)
            count <= reload;

         if (uf_ev)
            uf <= 1'b1;
         else if (wr_stat && bus.din[STAT_UF])
            uf <= 1'b0;

         // An explicit CTRL write overrides the one-shot stop on the same edge.
         if (wr_ctrl) begin
            arl   <= bus.din[CTRL_ARL];
            ie    <= bus.din[CTRL_IE];
            state <= bus.din[CTRL_RUN] ? ST_RUN : ST_STOP;
         end else begin
            case (state)
               ST_RUN:  if (uf_ev && !arl) state <= ST_STOP;
               default: state <= state;
            endcase
         end
      end
   end

   always_comb begin
      rdata = '0;
      if (bus.addr == ADDR_SIZE'(REG_CTRL)) begin
         rdata[CTRL_RUN] = run;
         rdata[CTRL_ARL] = arl;
         rdata[CTRL_IE]  = ie;
      end else if (bus.addr == ADDR_SIZE'(REG_RELOAD)) begin
         rdata = reload;
      end else if (bus.addr == ADDR_SIZE'(REG_COUNT)) begin
         rdata = count;
      end else if (bus.addr == ADDR_SIZE'(REG_STAT)) begin
         rdata[STAT_UF] = uf;
      end else if (bus.addr == ADDR_SIZE'(REG_PRESC)) begin
         rdata[PRE_WIDTH-1:0] = presc;
      end
   end

   assign bus.dout = bus.cs ? rdata : '0;
   assign irq      = uf && ie;
endmodule

// File: tb/tb_mbus_timer.sv
// Directed and randomized bus traffic against a cycle-level model of the
// timer's register rules, checked with immediate assertions.
module tb_mbus_timer;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic irq;
   int unsigned errors = 0;
   int unsigned checks = 0;

   mbus_timer_if #(.WIDTH(32), .ADDR_SIZE(4)) bus ();

   mbus_timer #(.WIDTH(32), .ADDR_SIZE(4), .PRE_WIDTH(16)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus),
      .irq   (irq)
   );

   always #10 clk = ~clk;

   // Reference model state
   logic        m_run, m_arl, m_ie, m_uf;
   logic [31:0] m_reload, m_count;
   logic [15:0] m_presc, m_pc;

   task automatic model_reset();
      m_run = 0; m_arl = 0; m_ie = 0; m_uf = 0;
      m_reload = 0; m_count = 0; m_presc = 0; m_pc = 0;
   endtask

   // One clock edge of the timer as described by its rules.
   task automatic model_step(input logic cs, input logic wen, input logic [3:0] a, input logic [31:0] d);
      logic w, tick, under;
      logic        n_run, n_arl, n_ie, n_uf;
      logic [31:0] n_reload, n_count;
      logic [15:0] n_presc, n_pc;
      w     = cs && wen;
      tick  = m_run && (m_pc == 0);
      under = tick && (m_count == 0);
      n_run = m_run; n_arl = m_arl; n_ie = m_ie; n_uf = m_uf;
      n_reload = m_reload; n_count = m_count; n_presc = m_presc;
      if (!m_run || tick) n_pc = m_presc;
      else                n_pc = m_pc - 16'd1;
      if (tick) begin
         if (m_count != 0) n_count = m_count - 1;
         else if (m_arl)   n_count = m_reload;
         else              n_run = 0;
      end
      if (w && a == 4'd3 && d[0]) n_uf = 0;
      if (under) n_uf = 1;
      if (w) begin
         case (a)
            4'd0: begin n_run = d[0]; n_arl = d[1]; n_ie = d[2]; end
            4'd1: n_reload = d;
            4'd2: n_count = d;
            4'd4: begin n_presc = d[15:0]; n_pc = d[15:0]; end
            default: ;
         endcase
      end
      m_run = n_run; m_arl = n_arl; m_ie = n_ie; m_uf = n_uf;
      m_reload = n_reload; m_count = n_count; m_presc = n_presc; m_pc = n_pc;
   endtask

   function automatic logic [31:0] model_read(input logic [3:0] a);
      case (a)
         4'd0: return {29'd0, m_ie, m_arl, m_run};
         4'd1: return m_reload;
         4'd2: return m_count;
         4'd3: return {31'd0, m_uf};
         4'd4: return {16'd0, m_presc};
         default: return 32'd0;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic bus_op(input logic cs, input logic wen, input logic [3:0] a, input logic [31:0] d);
      bus.cs = cs; bus.wen = wen; bus.addr = a; bus.din = d;
      @(posedge clk);
      model_step(cs, wen, a, d);
      #1;
      bus.cs = 0; bus.wen = 0;
   endtask

   task automatic wr(input logic [3:0] a, input logic [31:0] d);
      bus_op(1, 1, a, d);
   endtask

   task automatic idle(input int unsigned n);
      for (int unsigned i = 0; i < n; i++) bus_op(0, 0, 4'd0, 32'd0);
   endtask

   task automatic do_reset();
      reset = 1;
      @(posedge clk);
      model_reset();
      #1;
      reset = 0;
   endtask

   // Read with an explicit expected value.
   task automatic rd(input string tag, input logic [3:0] a, input logic [31:0] exp);
      bus.cs = 1; bus.wen = 0; bus.addr = a;
      #1;
      chk(tag, bus.dout, exp);
      bus.cs = 0;
   endtask

   task automatic rd_model(input string tag, input logic [3:0] a);
      rd(tag, a, model_read(a));
   endtask

   task automatic chk_all(input string tag);
      for (int unsigned a = 0; a < 5; a++) rd_model(tag, 4'(a));
      chk({tag, "_irq"}, {31'd0, irq}, {31'd0, m_uf & m_ie});
   endtask

   initial begin
      bus.cs = 0; bus.wen = 0; bus.addr = 0; bus.din = 0;
      model_reset();
      idle(2);
      #1;
      reset = 0;
      chk_all("por");

      // Reset mid-run
      wr(4, 0); wr(1, 9); wr(2, 20); wr(0, 7);
      idle(3);
      do_reset();
      for (int unsigned a = 0; a < 5; a++) rd("rst_reg", 4'(a), 32'd0);
      chk("rst_irq", {31'd0, irq}, 32'd0);

      // One-shot: underflow on the 4th edge after the CTRL write
      wr(4, 0); wr(2, 3); wr(0, 1);
      idle(3);
      rd("os_uf_early", 3, 0);
      rd("os_cnt_early", 2, 0);
      idle(1);
      rd("os_uf", 3, 1);
      rd("os_run", 0, 0);
      rd("os_cnt", 2, 0);
      chk_all("os");

      // Decode: deselected writes, unmapped offset, side-effect-free reads
      for (int unsigned a = 0; a < 5; a++) bus_op(0, 1, 4'(a), 32'hFFFF_FFFF);
      rd("dec_cnt", 2, 0);
      rd("dec_stat", 3, 1);
      rd("dec_ctrl", 0, 0);
      bus.cs = 0; bus.addr = 3; #1;
      chk("dec_cs0", bus.dout, 32'd0);
      rd("dec_unmapped", 9, 0);
      wr(9, 32'hDEAD_BEEF);
      rd("dec_unmapped_wr", 9, 0);
      for (int unsigned i = 0; i < 3; i++) rd("dec_stat_rep", 3, 1);

      // Auto-reload with prescale
      wr(3, 1);
      wr(4, 2); wr(1, 1); wr(2, 1); wr(0, 7);
      idle(5);
      rd("ar_uf_early", 3, 0);
      rd("ar_cnt_mid", 2, 0);
      idle(1);
      rd("ar_uf", 3, 1);
      chk("ar_irq", {31'd0, irq}, 32'd1);
      rd("ar_reload", 2, 1);
      rd("ar_ctrl", 0, 7);
      chk_all("ar");

      // W1C clear on the same edge as an underflow
      wr(0, 0); wr(3, 1);
      wr(4, 0); wr(1, 5); wr(2, 2); wr(0, 7);
      idle(2);
      wr(3, 1);
      rd("w1c_race_uf", 3, 1);
      chk("w1c_race_irq", {31'd0, irq}, 32'd1);
      wr(0, 4);
      wr(3, 1);
      rd("w1c_clr_uf", 3, 0);
      chk("w1c_clr_irq", {31'd0, irq}, 32'd0);

      // Bus write to COUNT beats a tick decrement
      wr(4, 0); wr(2, 32'h50); wr(0, 1);
      idle(2);
      wr(2, 32'h100);
      rd("prio_cnt", 2, 32'h100);
      idle(1);
      rd("prio_dec", 2, 32'hFF);
      wr(0, 0);
      chk_all("prio");

      // Randomized traffic
      for (int unsigned i = 0; i < 400; i++) begin
         int unsigned op;
         logic [3:0]  a;
         logic [31:0] d;
         op = $urandom_range(0, 99);
         a  = 4'($urandom_range(0, 15));
         if (a == 0 || a == 3)   d = $urandom;
         else if (op < 5)        d = $urandom;
         else                    d = 32'($urandom_range(0, 5)) | ($urandom & 32'hFFFF_0000 & {32{a == 4}});
         if (op == 99)      do_reset();
         else if (op < 55)  idle(1);
         else               bus_op($urandom_range(0, 3) != 0, 1, a, d);
         chk("rnd_irq", {31'd0, irq}, {31'd0, m_uf & m_ie});
         a = 4'($urandom_range(0, 15));
         rd_model("rnd_rd", a);
         if (i % 25 == 0) chk_all("rnd_all");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
